// File: rtl/arrow_field.sv
// arrow_field: multi-lane scrolling arrow renderer for the rhythm-game video path.
//
// Each lane holds up to SLOTS arrows. Every arrow has a y position, a direction,
// an inversion flag and a speed. Once per frame, on the frame tick, every active
// arrow moves down by speed+1 lines. An arrow that reaches V_ACTIVE is removed,
// and that lane's miss bit pulses for one cycle. Each hcount/vcount is turned
// into an RGB444 pixel by a two-stage pipeline: stage 1 tests every slot for a
// hit, and stage 2 priority-selects the colour.
//
// Optional build macro: ARROW_TARGET_EN. When it is defined, each lane column
// draws a grey (888) target row at TARGET_Y and at TARGET_Y+ARROW_SIZE-1.
// Arrows draw over the target.
//
// Ports:
//   clk             system clock
//   rst             synchronous reset, active low
//   hcount_in       current pixel x (11 bits)
//   vcount_in       current pixel y (10 bits)
//   valid_in        hcount/vcount valid this cycle
//   spawn_valid     spawn request
//   spawn_ready     spawn accepted when high together with spawn_valid (combinational)
//   spawn_lane      target lane of the spawn
//   spawn_direction 00 left, 01 down, 10 up, 11 right
//   spawn_inversed  draw the colour bitwise inverted
//   spawn_speed     scroll step minus one
//   pixel_out       RGB444 pixel, two cycles after its coordinates
//   valid_out       valid_in delayed by two cycles
//   miss_out        one-cycle per-lane drop pulse
module arrow_field #(
  parameter int LANES      = 4,
  parameter int SLOTS      = 4,
  parameter int ARROW_SIZE = 32,
  parameter int LANE_X0    = 480,
  parameter int LANE_PITCH = 80,
  parameter int V_ACTIVE   = 720,
  parameter int TARGET_Y   = 600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             valid_in,
  input  logic             spawn_valid,
  output logic             spawn_ready,
  input  logic [2:0]       spawn_lane,
  input  logic [1:0]       spawn_direction,
  input  logic             spawn_inversed,
  input  logic [2:0]       spawn_speed,
  output logic [11:0]      pixel_out,
  output logic             valid_out,
  output logic [LANES-1:0] miss_out
);

  localparam int AW = $clog2(ARROW_SIZE);
  localparam int N  = LANES * SLOTS;

`ifdef ARROW_TARGET_EN
  localparam bit TARGET_EN = 1'b1;
`else
  localparam bit TARGET_EN = 1'b0;
`endif

  // Left edge x of a lane column.
  function automatic logic [11:0] lane_base(input int l);
    return 12'(LANE_X0 + l * LANE_PITCH);
  endfunction

  // Triangle glyph test. With xo and yo as AW-bit offsets, ARROW_SIZE-1-v is simply ~v.
  function automatic logic glyph_mask(input logic [1:0] dir, input logic [AW-1:0] xo,
                                      input logic [AW-1:0] yo);
    logic [AW:0]   h;
    logic [AW+1:0] dx2;
    logic [AW+1:0] dy2;
    logic          m;
    h   = (AW+1)'(ARROW_SIZE / 2);
    dx2 = ({1'b0, xo} >= h) ? {{1'b0, xo} - h, 1'b0} : {h - {1'b0, xo}, 1'b0};
    dy2 = ({1'b0, yo} >= h) ? {{1'b0, yo} - h, 1'b0} : {h - {1'b0, yo}, 1'b0};
    case (dir)
      2'b10:   m = (dx2 <= {2'b00, yo});   // up
      2'b01:   m = (dx2 <= {2'b00, ~yo});  // down
      2'b00:   m = (dy2 <= {2'b00, xo});   // left
      2'b11:   m = (dy2 <= {2'b00, ~xo});  // right
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Base colour for each direction, optionally inverted.
  function automatic logic [11:0] arrow_colour(input logic [1:0] dir, input logic inv);
    logic [11:0] c;
    case (dir)
      2'b00:   c = 12'hF00;
      2'b01:   c = 12'h0F0;
      2'b10:   c = 12'h00F;
      2'b11:   c = 12'hFF0;
      default: c = 12'h000;
    endcase
    return inv ? ~c : c;
  endfunction

  // Slot state
  logic             r_active [LANES][SLOTS];
  logic [9:0]       r_y      [LANES][SLOTS];
  logic [1:0]       r_dir    [LANES][SLOTS];
  logic             r_inv    [LANES][SLOTS];
  logic [2:0]       r_speed  [LANES][SLOTS];

  logic [10:0]      w_ny     [LANES][SLOTS];
  logic             w_drop   [LANES][SLOTS];
  logic [LANES-1:0] w_miss;
  logic             w_frame_tick;
  logic             w_lane_free;
  logic [2:0]       w_slot_sel;
  logic             w_spawn_fire;

  // Render pipeline
  logic [11:0]      w_xoff   [LANES];
  logic [10:0]      w_yoff   [LANES][SLOTS];
  logic [N-1:0]     w_hit;
  logic [11:0]      w_col    [N];
  logic             w_tgt;
  logic [N-1:0]     r_hit;
  logic [11:0]      r_col    [N];
  logic             r_tgt;
  logic             r_valid1;
  logic [11:0]      w_pix;

  assign w_frame_tick = valid_in && (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));

  // Per-slot next position and drop detection for the frame update.
  always_comb begin
    w_miss = {LANES{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        // 11-bit sum so that a position past 1023 still compares correctly.
        w_ny[l][s]   = {1'b0, r_y[l][s]} + {8'd0, r_speed[l][s]} + 11'd1;
        w_drop[l][s] = r_active[l][s] && (w_ny[l][s] >= 11'(V_ACTIVE));
        w_miss[l]    = w_miss[l] | (w_frame_tick & w_drop[l][s]);
      end
    end
  end

  // Free-slot search in the requested lane (lowest index wins) and the spawn handshake.
  always_comb begin
    w_lane_free = 1'b0;
    w_slot_sel  = 3'd0;
    for (int l = 0; l < LANES; l++) begin
      if (spawn_lane == 3'(l)) begin
        for (int s = SLOTS - 1; s >= 0; s--) begin
          if (!r_active[l][s]) begin
            w_lane_free = 1'b1;
            w_slot_sel  = 3'(s);
          end else begin
            w_lane_free = w_lane_free;
            w_slot_sel  = w_slot_sel;
          end
        end
      end else begin
        w_lane_free = w_lane_free;
      end
    end
    spawn_ready  = rst && !w_frame_tick && ({1'b0, spawn_lane} < 4'(LANES)) && w_lane_free;
    w_spawn_fire = spawn_valid && spawn_ready;
  end

  // Slot registers: clear on reset, load on spawn, advance or drop on the frame tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < SLOTS; s++) begin
          r_active[l][s] <= 1'b0;
          r_y[l][s]      <= 10'd0;
          r_dir[l][s]    <= 2'd0;
          r_inv[l][s]    <= 1'b0;
          r_speed[l][s]  <= 3'd0;
        end
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < SLOTS; s++) begin
          // A spawn never coincides with a frame tick, so the two branches never overlap.
          if (w_spawn_fire && (spawn_lane == 3'(l)) && (w_slot_sel == 3'(s))) begin
            r_active[l][s] <= 1'b1;
            r_y[l][s]      <= 10'd0;
            r_dir[l][s]    <= spawn_direction;
            r_inv[l][s]    <= spawn_inversed;
            r_speed[l][s]  <= spawn_speed;
          end else if (w_frame_tick && r_active[l][s]) begin
            if (w_drop[l][s]) begin
              r_active[l][s] <= 1'b0;
            end else begin
              r_y[l][s] <= w_ny[l][s][9:0];
            end
          end
        end
      end
    end
  end

  // Stage 1 combinational: per-slot hit test, slot colour and target row.
  always_comb begin
    w_hit = {N{1'b0}};
    w_tgt = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      // A pixel left of the lane wraps to a large unsigned offset and falls out of range.
      w_xoff[l] = {1'b0, hcount_in} - lane_base(l);
      w_tgt = w_tgt | (TARGET_EN && (w_xoff[l] < 12'(ARROW_SIZE)) &&
                       ((vcount_in == 10'(TARGET_Y)) ||
                        (vcount_in == 10'(TARGET_Y + ARROW_SIZE - 1))));
      for (int s = 0; s < SLOTS; s++) begin
        w_yoff[l][s]       = {1'b0, vcount_in} - {1'b0, r_y[l][s]};
        w_col[l*SLOTS + s] = arrow_colour(r_dir[l][s], r_inv[l][s]);
        w_hit[l*SLOTS + s] = r_active[l][s] && (w_xoff[l] < 12'(ARROW_SIZE)) &&
                             (w_yoff[l][s] < 11'(ARROW_SIZE)) &&
                             glyph_mask(r_dir[l][s], w_xoff[l][AW-1:0], w_yoff[l][s][AW-1:0]);
      end
    end
  end

  // Stage 2 combinational: priority select. The scan runs downward so the lowest lane/slot is written last and wins.
  always_comb begin
    if (r_tgt) begin
      w_pix = 12'h888;
    end else begin
      w_pix = 12'h000;
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (r_hit[i]) begin
        w_pix = r_col[i];
      end else begin
        w_pix = w_pix;
      end
    end
  end

  // Pipeline registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hit     <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        r_col[i] <= 12'h000;
      end
      r_tgt     <= 1'b0;
      r_valid1  <= 1'b0;
      pixel_out <= 12'h000;
      valid_out <= 1'b0;
      miss_out  <= {LANES{1'b0}};
    end else begin
      r_hit     <= w_hit;
      for (int i = 0; i < N; i++) begin
        r_col[i] <= w_col[i];
      end
      r_tgt     <= w_tgt;
      r_valid1  <= valid_in;
      pixel_out <= w_pix;
      valid_out <= r_valid1;
      miss_out  <= w_miss;
    end
  end

endmodule

// File: tb/tb_arrow_field.sv
// Directed testbench for arrow_field. A second instance with LANE_PITCH=0 stacks
// all lanes at the same x, so that overlap priority between lanes can be exercised.
module tb_arrow_field;

  logic        clk;
  logic        rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        valid_in;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [2:0]  spawn_lane;
  logic [1:0]  spawn_direction;
  logic        spawn_inversed;
  logic [2:0]  spawn_speed;
  logic [11:0] pixel_out;
  logic        valid_out;
  logic [3:0]  miss_out;
  logic        ready2;
  logic [11:0] pix2;
  logic        vo2;
  logic [3:0]  miss2;

  int n_tests = 0;
  int n_fail  = 0;

  arrow_field dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in), .valid_in(valid_in),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_lane(spawn_lane),
    .spawn_direction(spawn_direction), .spawn_inversed(spawn_inversed), .spawn_speed(spawn_speed),
    .pixel_out(pixel_out), .valid_out(valid_out), .miss_out(miss_out)
  );

  arrow_field #(.LANE_PITCH(0)) dut2 (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in), .valid_in(valid_in),
    .spawn_valid(spawn_valid), .spawn_ready(ready2), .spawn_lane(spawn_lane),
    .spawn_direction(spawn_direction), .spawn_inversed(spawn_inversed), .spawn_speed(spawn_speed),
    .pixel_out(pix2), .valid_out(vo2), .miss_out(miss2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0; spawn_valid = 1'b0; hcount_in = 11'd0; vcount_in = 10'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic spawn(input logic [2:0] lane, input logic [1:0] dir, input logic inv,
                       input logic [2:0] spd, output logic rdy);
    @(negedge clk);
    spawn_valid = 1'b1; spawn_lane = lane; spawn_direction = dir;
    spawn_inversed = inv; spawn_speed = spd;
    #1 rdy = spawn_ready;
    @(negedge clk);
    spawn_valid = 1'b0;
  endtask

  task automatic frame_tick();
    @(negedge clk);
    valid_in = 1'b1; hcount_in = 11'd0; vcount_in = 10'd720;
    @(negedge clk);
    valid_in = 1'b0; vcount_in = 10'd0;
  endtask

  task automatic scan(input logic [10:0] h, input logic [9:0] v,
                      output logic [11:0] p, output logic [11:0] p2, output logic vo);
    @(negedge clk);
    valid_in = 1'b1; hcount_in = h; vcount_in = v;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    p = pixel_out; p2 = pix2; vo = valid_out;
  endtask

  task automatic test_reset();
    rst = 1'b0; spawn_valid = 1'b1; spawn_lane = 3'd0; spawn_direction = 2'b10;
    spawn_inversed = 1'b0; spawn_speed = 3'd0; valid_in = 1'b0;
    hcount_in = 11'd0; vcount_in = 10'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (spawn_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", spawn_ready); end
    n_tests++; if (pixel_out !== 12'h000) begin n_fail++; $display("FAIL reset_pixel: got %h want 000", pixel_out); end
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_tests++; if (miss_out !== 4'b0000) begin n_fail++; $display("FAIL reset_miss: got %b want 0000", miss_out); end
    n_tests++; if ({ready2, pix2, vo2, miss2} !== 18'd0) begin n_fail++; $display("FAIL reset_dut2: got %h want 0", {ready2, pix2, vo2, miss2}); end
    spawn_valid = 1'b0; rst = 1'b1;
  endtask

  task automatic test_spawn_render();
    logic rdy; logic [11:0] p; logic [11:0] p2; logic vo;
    do_reset();
    spawn(3'd0, 2'b10, 1'b0, 3'd0, rdy);
    n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL spawn_ready: got %b want 1", rdy); end
    // Back-to-back pixels (496,0) then (480,0).
    @(negedge clk); valid_in = 1'b1; hcount_in = 11'd496; vcount_in = 10'd0;
    @(negedge clk); hcount_in = 11'd480;
    @(negedge clk); valid_in = 1'b0;
    n_tests++; if (pixel_out !== 12'h00F) begin n_fail++; $display("FAIL render_tip: got %h want 00F", pixel_out); end
    n_tests++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL render_valid: got %b want 1", valid_out); end
    @(negedge clk);
    n_tests++; if (pixel_out !== 12'h000) begin n_fail++; $display("FAIL render_corner: got %h want 000", pixel_out); end
    repeat (10) frame_tick();
    scan(11'd496, 10'd10, p, p2, vo);
    n_tests++; if (p !== 12'h00F) begin n_fail++; $display("FAIL scroll_top: got %h want 00F", p); end
    scan(11'd496, 10'd9, p, p2, vo);
    n_tests++; if (p !== 12'h000) begin n_fail++; $display("FAIL scroll_above: got %h want 000", p); end
  endtask

  task automatic test_lane_full();
    logic rdy;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      spawn(3'd1, 2'b01, 1'b0, 3'd0, rdy);
      n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL fill_lane1_%0d: got %b want 1", i, rdy); end
    end
    spawn(3'd1, 2'b01, 1'b0, 3'd0, rdy);
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL lane_full: got %b want 0", rdy); end
    spawn(3'd7, 2'b01, 1'b0, 3'd0, rdy);
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL bad_lane: got %b want 0", rdy); end
    // Spawn that coincides with a frame tick is refused.
    @(negedge clk);
    valid_in = 1'b1; hcount_in = 11'd0; vcount_in = 10'd720;
    spawn_valid = 1'b1; spawn_lane = 3'd0;
    #1 rdy = spawn_ready;
    @(negedge clk);
    valid_in = 1'b0; spawn_valid = 1'b0; vcount_in = 10'd0;
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL tick_spawn: got %b want 0", rdy); end
  endtask

  task automatic test_miss();
    logic rdy; logic [11:0] p; logic [11:0] p2; logic vo;
    do_reset();
    spawn(3'd2, 2'b01, 1'b0, 3'd7, rdy);
    for (int i = 0; i < 3; i++) spawn(3'd2, 2'b01, 1'b0, 3'd0, rdy);
    repeat (89) frame_tick();
    scan(11'd656, 10'd712, p, p2, vo);
    n_tests++; if (p !== 12'h0F0) begin n_fail++; $display("FAIL at_712: got %h want 0F0", p); end
    spawn(3'd2, 2'b01, 1'b0, 3'd0, rdy);
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL lane2_full: got %b want 0", rdy); end
    @(negedge clk); valid_in = 1'b1; hcount_in = 11'd0; vcount_in = 10'd720;
    @(negedge clk); valid_in = 1'b0; vcount_in = 10'd0;
    n_tests++; if (miss_out !== 4'b0100) begin n_fail++; $display("FAIL miss_pulse: got %b want 0100", miss_out); end
    @(negedge clk);
    n_tests++; if (miss_out !== 4'b0000) begin n_fail++; $display("FAIL miss_one_cycle: got %b want 0000", miss_out); end
    spawn(3'd2, 2'b01, 1'b0, 3'd0, rdy);
    n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL slot_freed: got %b want 1", rdy); end
    scan(11'd656, 10'd712, p, p2, vo);
    n_tests++; if (p !== 12'h000) begin n_fail++; $display("FAIL dropped_gone: got %h want 000", p); end
  endtask

  task automatic test_priority();
    logic rdy; logic [11:0] p; logic [11:0] p2; logic vo;
    do_reset();
    spawn(3'd0, 2'b00, 1'b1, 3'd0, rdy);  // lane0 slot0 inversed left
    spawn(3'd0, 2'b01, 1'b0, 3'd0, rdy);  // lane0 slot1 down
    spawn(3'd1, 2'b10, 1'b0, 3'd0, rdy);  // lane1 slot0 up
    spawn(3'd3, 2'b11, 1'b0, 3'd0, rdy);  // lane3 slot0 right
    scan(11'd496, 10'd16, p, p2, vo);
    n_tests++; if (p !== 12'h0FF) begin n_fail++; $display("FAIL slot_prio: got %h want 0FF", p); end
    n_tests++; if (p2 !== 12'h0FF) begin n_fail++; $display("FAIL lane0_wins: got %h want 0FF", p2); end
    scan(11'd496, 10'd31, p, p2, vo);
    n_tests++; if (p !== 12'h0F0) begin n_fail++; $display("FAIL down_only: got %h want 0F0", p); end
    n_tests++; if (p2 !== 12'h0F0) begin n_fail++; $display("FAIL lane_before_slot: got %h want 0F0", p2); end
    scan(11'd576, 10'd31, p, p2, vo);
    n_tests++; if (p !== 12'h00F) begin n_fail++; $display("FAIL lane1_up: got %h want 00F", p); end
    scan(11'd751, 10'd16, p, p2, vo);
    n_tests++; if (p !== 12'hFF0) begin n_fail++; $display("FAIL right_tip: got %h want FF0", p); end
    scan(11'd751, 10'd15, p, p2, vo);
    n_tests++; if (p !== 12'h000) begin n_fail++; $display("FAIL right_edge: got %h want 000", p); end
  endtask

  task automatic test_target();
    logic rdy; logic [11:0] p; logic [11:0] p2; logic vo;
    do_reset();
`ifdef ARROW_TARGET_EN
    scan(11'd490, 10'd600, p, p2, vo);
    n_tests++; if (p !== 12'h888) begin n_fail++; $display("FAIL target_row: got %h want 888", p); end
    scan(11'd490, 10'd599, p, p2, vo);
    n_tests++; if (p !== 12'h000) begin n_fail++; $display("FAIL target_off: got %h want 000", p); end
    spawn(3'd0, 2'b10, 1'b0, 3'd7, rdy);
    repeat (73) frame_tick();
    scan(11'd490, 10'd600, p, p2, vo);
    n_tests++; if (p !== 12'h00F) begin n_fail++; $display("FAIL arrow_over_target: got %h want 00F", p); end
`else
    scan(11'd490, 10'd600, p, p2, vo);
    n_tests++; if (p !== 12'h000) begin n_fail++; $display("FAIL no_target: got %h want 000", p); end
    spawn(3'd0, 2'b10, 1'b0, 3'd7, rdy);
    n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL target_spawn: got %b want 1", rdy); end
`endif
  endtask

  initial begin
    test_reset();
    test_spawn_render();
    test_lane_full();
    test_miss();
    test_priority();
    test_target();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arrow_field.md
Name: arrow_field

Overview:
- Multi-lane successor to the single-arrow sprite renderer in the rhythm-game video path.
- Holds up to SLOTS scrolling arrows per lane across LANES lanes. Advances them once per frame by a per-arrow speed.
- Renders the composite 12-bit pixel for each hcount/vcount, and reports arrows that fall off the bottom as per-lane miss pulses.

Parameters:
- LANES, 4, number of lane columns (1..8).
- SLOTS, 4, arrow slots per lane (1..8).
- ARROW_SIZE, 32, glyph square edge in pixels (power of 2).
- LANE_X0, 480, x of lane 0 left edge.
- LANE_PITCH, 80, x spacing between lane left edges.
- V_ACTIVE, 720, active lines; frame update and drop limit.
- TARGET_Y, 600, y of target row (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active low.
- hcount_in  in  11  current pixel x.
- vcount_in  in  10  current pixel y.
- valid_in  in  1  hcount/vcount valid this cycle.
- spawn_valid  in  1  spawn request.
- spawn_ready  out  1  spawn accepted when high with spawn_valid.
- spawn_lane  in  3  target lane.
- spawn_direction  in  2  00 left, 01 down, 10 up, 11 right.
- spawn_inversed  in  1  draw colour inverted.
- spawn_speed  in  3  scroll step − 1 (pixels per frame = speed+1).
- pixel_out  out  12  RGB444 pixel.
- valid_out  out  1  pixel_out valid.
- miss_out  out  LANES  one-cycle per-lane drop pulse.

Behaviour:
- Clock clk; reset rst is synchronous and active-low: when rst==0 at a rising edge, all slots are cleared next cycle.
- Reset values: pixel_out=0, valid_out=0, miss_out=0, spawn_ready=0. Reset mid-frame discards all arrows and pipeline contents.
- Slot state: active bit, y[9:0], direction, inversed, speed.
- frame_tick = valid_in && hcount_in==0 && vcount_in==V_ACTIVE.
- Update (frame_tick cycle): for each active slot, ny = y + speed + 1, computed 11 bits wide.
  - If ny >= V_ACTIVE: slot cleared and that lane's miss_out bit pulses on the next cycle (multiple lanes may pulse together).
  - Otherwise y <= ny.
- spawn_ready is combinational: high iff rst==1, !frame_tick, spawn_lane < LANES, and the lane has a free slot. It is low otherwise.
- On accept, the lowest-index free slot of the lane loads y=0 plus the spawn fields, visible from the next cycle.
- Render pipeline, 2-cycle latency:
  - Stage 1 computes per-slot hit.
  - Stage 2 priority-selects the colour and registers pixel_out.
  - valid_out = valid_in delayed 2 cycles.
- Hit test:
  - Hit when the slot is active, x_off = hcount_in − (LANE_X0 + lane·LANE_PITCH) is in [0,ARROW_SIZE), y_off = vcount_in − y is in [0,ARROW_SIZE), and the glyph mask is set.
- Glyph mask is a triangle with h=ARROW_SIZE/2:
  - up: 2·|x_off−h| <= y_off
  - down: 2·|x_off−h| <= ARROW_SIZE−1−y_off
  - left: 2·|y_off−h| <= x_off
  - right: 2·|y_off−h| <= ARROW_SIZE−1−x_off
- Colours:
  - left F00, down 0F0, up 00F, right FF0.
  - inversed arrows output the bitwise NOT.
- Overlap priority: lowest lane, then lowest slot wins. No hit → 000.
- When valid_in is low, pixel_out is still produced from the delayed coordinates, but consumers ignore it.
- A spawn in a frame_tick cycle is refused (ready low); the requester holds until a later cycle.

Optional Feature:
- ARROW_TARGET_EN defined: for each lane column, a pixel with vcount==TARGET_Y or vcount==TARGET_Y+ARROW_SIZE−1 inside the lane x range and with no arrow hit outputs 888. Arrows always draw over the target.
- Undefined: no target drawn; TARGET_Y is unused.

Test Plan:
1. rst=0 for 2 cycles with spawn_valid=1 → spawn_ready=0, pixel_out=000, valid_out=0, miss_out=0.
2. Spawn lane 0, dir up, speed 0, then scan (496,0) and (480,0) → after 2 cycles pixel_out 00F at (496,0) and 000 at (480,0). After 10 frame_ticks the glyph top is at y=10.
3. Spawn SLOTS=4 arrows into lane 1 → spawn_ready low on the 5th request. Spawn lane 7 with LANES=4 → spawn_ready=0.
4. Lane 2 arrow, speed 7, with y reaching 712 → at the next frame_tick, ny=720, miss_out=0100 for exactly one cycle, and the slot becomes free.
5. Lane 0 inversed left arrow overlapping the same pixel as a lane 1 arrow → pixel_out=0FF (lane 0 wins).
6. With ARROW_TARGET_EN, scan (490,600) with no arrows → 888. Place an up arrow covering it → 00F.
